// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared definitions for the execute -> memory -> writeback pipeline.
//   DATA_W  : datapath / ALU / memory data width
//   ADDR_W  : register index width (16 registers)
//   PC_REG  : register index of the program counter (never forwarded)
//   ctrl_t  : control bundle carried by every pipeline register
//   Optional feature macro used by the files that import this package: FWD_EN
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] PC_REG = 4'd15;

   typedef struct packed {
      logic regWrite;
      logic memToReg;
      logic memWrite;
      logic PCSrc;
   } ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Hazard detection and operand selection for one execute source operand.
//   Ports:
//     ra        in   source register index of the execute instruction
//     en_m      in   M stage holds a valid register-writing instruction
//     wa3_m     in   M stage destination register
//     val_m     in   value the M stage instruction will write
//     en_w      in   W stage holds a valid register-writing instruction
//     wa3_w     in   W stage destination register
//     val_w     in   value the W stage instruction is writing
//     rd        in   register-file value read for ra
//     fwd       out  operand value presented to execute
//     hazard    out  ra is produced by an instruction still in M or W
//   Macro FWD_EN: when defined, fwd picks M over W over rd; when undefined,
//   fwd is always rd and the caller stalls on hazard instead.
// -----------------------------------------------------------------------------
module fwd_select
   import cpu_pipe_pkg::*;
(
   input  logic [ADDR_W-1:0] ra,
   input  logic              en_m,
   input  logic [ADDR_W-1:0] wa3_m,
   input  logic [DATA_W-1:0] val_m,
   input  logic              en_w,
   input  logic [ADDR_W-1:0] wa3_w,
   input  logic [DATA_W-1:0] val_w,
   input  logic [DATA_W-1:0] rd,
   output logic [DATA_W-1:0] fwd,
   output logic              hazard
);

   logic hit_m;
   logic hit_w;

   // The PC is supplied by fetch rather than the register file, so a write
   // to it never counts as a data dependency.
   assign hit_m  = en_m && (wa3_m == ra) && (ra != PC_REG);
   assign hit_w  = en_w && (wa3_w == ra) && (ra != PC_REG);
   assign hazard = hit_m | hit_w;

`ifdef FWD_EN
   // The younger producer (M) holds the newest value, so it wins over W.
   always_comb begin
      fwd = rd;
      if (hit_m) begin
         fwd = val_m;
      end else if (hit_w) begin
         fwd = val_w;
      end
   end
`else
   logic unused_vals;
   assign unused_vals = ^{val_m, val_w};
   assign fwd         = rd;
`endif

endmodule

// File: rtl/exec_writeback_pipe.sv
// -----------------------------------------------------------------------------
// exec_writeback_pipe
//   Takes execute-stage results/control, registers them through the M and W
//   stages, drives data memory and the register-file write port, and returns
//   forwarded operands (or a stall request) to execute.
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     validE, flushE                   execute instruction valid / kill it
//     regWriteE, memToRegE,
//     memWriteE, PCSrcE                execute control
//     WA3E, RA1E, RA2E                 destination / source registers
//     rd1E, rd2E                       register-file read values
//     aluResultE                       ALU result (memory address)
//     readDataM                        data memory read data (combinational)
//     aluOutM, writeDataM, memWriteM   data memory address / data / strobe
//     resultW, WA3W, regWriteW         register-file write port
//     PCSrcW                           PC write enable
//     fwdA, fwdB                       operands for execute SrcA / SrcB
//     stallE                           hold decode->execute register and fetch
//   Macro FWD_EN: defined -> operands forwarded from M/W, stallE tied 0;
//   undefined -> no forwarding, execute stalls until the producer retires.
//   Latency: an instruction in E at cycle n drives memory at n+1 and writes
//   the register file at n+2.
// -----------------------------------------------------------------------------
module exec_writeback_pipe
   import cpu_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              validE,
   input  logic              flushE,
   input  logic              regWriteE,
   input  logic              memToRegE,
   input  logic              memWriteE,
   input  logic              PCSrcE,
   input  logic [ADDR_W-1:0] WA3E,
   input  logic [ADDR_W-1:0] RA1E,
   input  logic [ADDR_W-1:0] RA2E,
   input  logic [DATA_W-1:0] rd1E,
   input  logic [DATA_W-1:0] rd2E,
   input  logic [DATA_W-1:0] aluResultE,
   input  logic [DATA_W-1:0] readDataM,
   output logic [DATA_W-1:0] aluOutM,
   output logic [DATA_W-1:0] writeDataM,
   output logic              memWriteM,
   output logic [DATA_W-1:0] resultW,
   output logic [ADDR_W-1:0] WA3W,
   output logic              regWriteW,
   output logic              PCSrcW,
   output logic [DATA_W-1:0] fwdA,
   output logic [DATA_W-1:0] fwdB,
   output logic              stallE
);

   // ---------------------------------------------------------------- state
   logic              valid_m_reg;
   ctrl_t             ctrl_m_reg;
   logic [ADDR_W-1:0] wa3_m_reg;
   logic [DATA_W-1:0] alu_m_reg;
   logic [DATA_W-1:0] wd_m_reg;

   logic              valid_w_reg;
   ctrl_t             ctrl_w_reg;
   logic [ADDR_W-1:0] wa3_w_reg;
   logic [DATA_W-1:0] result_w_reg;

   // ------------------------------------------------------------ combinational
   ctrl_t             ctrl_e;
   logic [DATA_W-1:0] result_m;
   logic              en_m;
   logic              en_w;
   logic              stall_e;

   logic [ADDR_W-1:0] ra_arr  [2];
   logic [DATA_W-1:0] rd_arr  [2];
   logic [DATA_W-1:0] fwd_arr [2];
   logic              haz_arr [2];

   assign ctrl_e = '{regWrite: regWriteE, memToReg: memToRegE,
                     memWrite: memWriteE, PCSrc: PCSrcE};

   // Value the M instruction will eventually write back; also the M-stage
   // forwarding source so a load result is usable in the same cycle.
   assign result_m = ctrl_m_reg.memToReg ? readDataM : alu_m_reg;

   assign en_m = valid_m_reg & ctrl_m_reg.regWrite;
   assign en_w = valid_w_reg & ctrl_w_reg.regWrite;

   assign ra_arr[0] = RA1E;
   assign ra_arr[1] = RA2E;
   assign rd_arr[0] = rd1E;
   assign rd_arr[1] = rd2E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         fwd_select u_fwd_select (
            .ra     (ra_arr[gi]),
            .en_m   (en_m),
            .wa3_m  (wa3_m_reg),
            .val_m  (result_m),
            .en_w   (en_w),
            .wa3_w  (wa3_w_reg),
            .val_w  (result_w_reg),
            .rd     (rd_arr[gi]),
            .fwd    (fwd_arr[gi]),
            .hazard (haz_arr[gi])
         );
      end
   endgenerate

   assign fwdA = fwd_arr[0];
   assign fwdB = fwd_arr[1];

`ifdef FWD_EN
   logic unused_haz;
   assign unused_haz = haz_arr[0] ^ haz_arr[1];
   assign stall_e    = 1'b0;
`else
   // Masked by rst so that no stall is reported in the reset cycle while the
   // stage registers still hold pre-reset contents.
   assign stall_e = ~rst & validE & (haz_arr[0] | haz_arr[1]);
`endif

   assign stallE = stall_e;

   // ---------------------------------------------------------- pipeline regs
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_m_reg  <= 1'b0;
         ctrl_m_reg   <= '0;
         wa3_m_reg    <= '0;
         alu_m_reg    <= '0;
         wd_m_reg     <= '0;
         valid_w_reg  <= 1'b0;
         ctrl_w_reg   <= '0;
         wa3_w_reg    <= '0;
         result_w_reg <= '0;
      end else begin
         // Flush and stall both turn the captured slot into a bubble; the
         // data fields are copied regardless since control is gated by valid.
         valid_m_reg  <= validE & ~flushE & ~stall_e;
         ctrl_m_reg   <= ctrl_e;
         wa3_m_reg    <= WA3E;
         alu_m_reg    <= aluResultE;
         wd_m_reg     <= fwdB;
         valid_w_reg  <= valid_m_reg;
         ctrl_w_reg   <= ctrl_m_reg;
         wa3_w_reg    <= wa3_m_reg;
         result_w_reg <= result_m;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Strobes are gated by the stage valid bit, and by rst so that in-flight
   // instructions are discarded without a write in the reset cycle itself.
   assign aluOutM    = alu_m_reg;
   assign writeDataM = wd_m_reg;
   assign memWriteM  = ~rst & valid_m_reg & ctrl_m_reg.memWrite;

   assign resultW    = result_w_reg;
   assign WA3W       = wa3_w_reg;
   assign regWriteW  = ~rst & valid_w_reg & ctrl_w_reg.regWrite;
   assign PCSrcW     = ~rst & valid_w_reg & ctrl_w_reg.PCSrc;

endmodule
